pong_match_ctrl: RTL and testbench

Match sequencer for the pong game. It gates the per-frame ball physics step, issues serves with direction and initial speed, and escalates ball speed on paddle hits. It also keeps both scores, detects the winning score, and handles pause. It sits between the frame-tick source and the ball/paddle physics datapath, and feeds the score displays (on-screen digits and board SSD).

---
 rtl/pong_match_ctrl_pkg.sv | 31 +++
 rtl/pong_match_ctrl_if.sv | 43 ++++
 rtl/pong_match_ctrl_tick_countdown.sv | 40 ++++
 rtl/pong_match_ctrl.sv | 156 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pong_match_ctrl_pkg.sv
// ============================================================================
// Module      : pong_pkg
// Description : Shared encodings for the pong match sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

   localparam int SCORE_W = 4;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_SERVE_WAIT = 3'd1;
   localparam logic [2:0] ST_PLAY       = 3'd2;
   localparam logic [2:0] ST_SCORE      = 3'd3;
   localparam logic [2:0] ST_GAME_OVER  = 3'd4;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Scores stop at the winning value rather than wrapping.
   function automatic logic [SCORE_W-1:0] score_inc(
      input logic [SCORE_W-1:0] i_score,
      input logic [SCORE_W-1:0] i_limit
   );
      return (i_score >= i_limit) ? i_score : i_score + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pong_match_ctrl_if.sv
// ============================================================================
// Module      : pong_match_ctrl_if
// Description : Frame/event inputs and match outputs of the pong sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pong_match_ctrl_if #(
   parameter int SPD_W = 8
) ();

   logic                         tick;
   logic                         start;
   logic                         pause;
   logic                         goal_left;
   logic                         goal_right;
   logic                         paddle_hit;
   logic                         phys_en;
   logic                         serve;
   logic                         serve_dir;
   logic [SPD_W-1:0]             ball_speed;
   logic [pong_pkg::SCORE_W-1:0] p1_score;
   logic [pong_pkg::SCORE_W-1:0] p2_score;
   logic                         game_over;
   logic                         winner;
   logic [2:0]                   state_o;

   // master: the match controller; slave: tick source, physics and displays
   modport master (
      input  tick, start, pause, goal_left, goal_right, paddle_hit,
      output phys_en, serve, serve_dir, ball_speed, p1_score, p2_score,
             game_over, winner, state_o
   );

   modport slave (
      output tick, start, pause, goal_left, goal_right, paddle_hit,
      input  phys_en, serve, serve_dir, ball_speed, p1_score, p2_score,
             game_over, winner, state_o
   );

endinterface

`default_nettype wire

// File: rtl/pong_match_ctrl_tick_countdown.sv
// ============================================================================
// Module      : tick_countdown
// Description : Loadable frame-tick down-counter with hold and expiry flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_countdown #(
   parameter int CNT_W = 8
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_load,
   input  wire logic [CNT_W-1:0] i_load_val,
   input  wire logic             i_tick,
   input  wire logic             i_hold,
   output logic                  o_done
);

   logic [CNT_W-1:0] r_count;
   logic             w_step;

   assign w_step = i_tick & ~i_hold;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (w_step && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Expiry is flagged in the same clk as the tick that consumes the last count.
   assign o_done = (r_count == '0) || (w_step && (r_count == CNT_W'(1)));

endmodule

`default_nettype wire

// File: rtl/pong_match_ctrl.sv
// ============================================================================
// Module      : pong_match_ctrl
// Description : Pong match sequencer: serves, physics gating, speed, scoring.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_DELAY = 60,
   parameter int SCORE_HOLD  = 30,
   parameter int INIT_SPEED  = 1,
   parameter int MAX_SPEED   = 15,
   parameter int SPD_W       = 8,
   parameter int CNT_W       = 8
) (
   input  wire logic      clk,
   input  wire logic      reset,
   pong_match_ctrl_if.master bus
);

   localparam logic [CNT_W-1:0]   c_serve_delay = CNT_W'(SERVE_DELAY);
   localparam logic [CNT_W-1:0]   c_score_hold  = CNT_W'(SCORE_HOLD);
   localparam logic [SPD_W-1:0]   c_init_speed  = SPD_W'(INIT_SPEED);
   localparam logic [SPD_W-1:0]   c_max_speed   = SPD_W'(MAX_SPEED);
   localparam logic [SCORE_W-1:0] c_win_score   = SCORE_W'(WIN_SCORE);

   logic [2:0]         r_state;
   logic               r_start_q;
   logic               r_phys_en;
   logic               r_serve_dir;
   logic               r_winner;
   logic [SPD_W-1:0]   r_ball_speed;
   logic [SCORE_W-1:0] r_p1_score;
   logic [SCORE_W-1:0] r_p2_score;

   logic               w_start_rise;
   logic               w_step;
   logic               w_goal_any;
   logic               w_win;
   logic               w_cnt_tick;
   logic               w_cnt_done;
   logic               w_load;
   logic [CNT_W-1:0]   w_load_val;

   assign w_start_rise = bus.start & ~r_start_q;
   assign w_step       = bus.tick & ~bus.pause;
   assign w_goal_any   = bus.goal_left | bus.goal_right;
   assign w_win        = (r_p1_score == c_win_score) || (r_p2_score == c_win_score);
   assign w_cnt_tick   = bus.tick && ((r_state == ST_SERVE_WAIT) || (r_state == ST_SCORE));

   always_comb begin
      w_load     = 1'b0;
      w_load_val = c_serve_delay;
      case (r_state)
         ST_IDLE, ST_GAME_OVER: w_load = w_start_rise;
         ST_PLAY: begin
            w_load     = w_goal_any;
            w_load_val = c_score_hold;
         end
         ST_SCORE: w_load = w_cnt_done & ~w_win;
         default:  w_load = 1'b0;
      endcase
   end

   tick_countdown #(
      .CNT_W (CNT_W)
   ) u_countdown (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_tick     (w_cnt_tick),
      .i_hold     (bus.pause),
      .o_done     (w_cnt_done)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_start_q    <= 1'b0;
         r_phys_en    <= 1'b0;
         r_serve_dir  <= DIR_RIGHT;
         r_winner     <= 1'b0;
         r_ball_speed <= c_init_speed;
         r_p1_score   <= '0;
         r_p2_score   <= '0;
      end else begin
         r_start_q <= bus.start;
         // A goal tick already hands over to SCORE, so it must not step physics.
         r_phys_en <= (r_state == ST_PLAY) && w_step && !w_goal_any;

         case (r_state)
            ST_IDLE: begin
               if (w_start_rise) r_state <= ST_SERVE_WAIT;
            end
            ST_SERVE_WAIT: begin
               if (w_cnt_done) begin
                  r_ball_speed <= c_init_speed;
                  r_state      <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (bus.goal_left && bus.goal_right) begin
                  r_state <= ST_SCORE;
               end else if (bus.goal_right) begin
                  r_p1_score  <= score_inc(r_p1_score, c_win_score);
                  r_serve_dir <= DIR_RIGHT;
                  r_state     <= ST_SCORE;
               end else if (bus.goal_left) begin
                  r_p2_score  <= score_inc(r_p2_score, c_win_score);
                  r_serve_dir <= DIR_LEFT;
                  r_state     <= ST_SCORE;
               end else if (bus.paddle_hit) begin
                  r_ball_speed <= (r_ball_speed >= c_max_speed) ? c_max_speed
                                                                : r_ball_speed + 1'b1;
               end
            end
            ST_SCORE: begin
               if (w_cnt_done) begin
                  if (w_win) begin
                     r_winner <= (r_p2_score == c_win_score);
                     r_state  <= ST_GAME_OVER;
                  end else begin
                     r_state  <= ST_SERVE_WAIT;
                  end
               end
            end
            ST_GAME_OVER: begin
               if (w_start_rise) begin
                  r_p1_score  <= '0;
                  r_p2_score  <= '0;
                  r_serve_dir <= DIR_RIGHT;
                  r_state     <= ST_SERVE_WAIT;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.phys_en    = r_phys_en;
   assign bus.serve      = (r_state == ST_SERVE_WAIT) && w_cnt_done;
   assign bus.serve_dir  = r_serve_dir;
   assign bus.ball_speed = r_ball_speed;
   assign bus.p1_score   = r_p1_score;
   assign bus.p2_score   = r_p2_score;
   assign bus.game_over  = (r_state == ST_GAME_OVER);
   assign bus.winner     = r_winner;
   assign bus.state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// ============================================================================
// Module      : tb_pong_match_ctrl
// Description : Directed self-checking bench for the pong match sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pong_match_ctrl;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   pong_match_ctrl_if #(.SPD_W(8)) bus ();

   pong_match_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         cyc();
         bus.tick = 1'b0;
         cyc();
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_state"},  32'(bus.state_o),    32'd0);
      chk({tag, "_phys"},   32'(bus.phys_en),    32'd0);
      chk({tag, "_serve"},  32'(bus.serve),      32'd0);
      chk({tag, "_dir"},    32'(bus.serve_dir),  32'd1);
      chk({tag, "_speed"},  32'(bus.ball_speed), 32'd1);
      chk({tag, "_p1"},     32'(bus.p1_score),   32'd0);
      chk({tag, "_p2"},     32'(bus.p2_score),   32'd0);
      chk({tag, "_gover"},  32'(bus.game_over),  32'd0);
      chk({tag, "_winner"}, 32'(bus.winner),     32'd0);
   endtask

   // Runs pre_ticks ticks, then checks the serve pulse on the following tick.
   task automatic serve_seq(input string tag, input int pre_ticks, input logic exp_dir);
      tick_n(pre_ticks);
      chk({tag, "_pre_state"}, 32'(bus.state_o), 32'd1);
      chk({tag, "_pre_serve"}, 32'(bus.serve),   32'd0);
      bus.tick = 1'b1;
      #2;
      chk({tag, "_serve"}, 32'(bus.serve), 32'd1);
      cyc();
      bus.tick = 1'b0;
      chk({tag, "_serve_gone"}, 32'(bus.serve),      32'd0);
      chk({tag, "_state"},      32'(bus.state_o),    32'd2);
      chk({tag, "_speed"},      32'(bus.ball_speed), 32'd1);
      chk({tag, "_dir"},        32'(bus.serve_dir),  32'(exp_dir));
      cyc();
   endtask

   initial begin
      logic seen_phys;
      n_vec = 0;
      n_err = 0;
      reset          = 1'b0;
      bus.tick       = 1'b0;
      bus.start      = 1'b0;
      bus.pause      = 1'b0;
      bus.goal_left  = 1'b0;
      bus.goal_right = 1'b0;
      bus.paddle_hit = 1'b0;
      repeat (3) cyc();
      check_reset_vals("rst");
      reset = 1'b1;
      cyc();

      pulse_start();
      chk("start_sw", 32'(bus.state_o), 32'd1);
      cyc();
      serve_seq("serve1", 59, 1'b1);

      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      chk("phys_one", 32'(bus.phys_en), 32'd1);
      cyc();
      chk("phys_zero", 32'(bus.phys_en), 32'd0);

      for (int i = 0; i < 3; i++) begin
         bus.paddle_hit = 1'b1; cyc(); bus.paddle_hit = 1'b0; cyc();
      end
      chk("speed_4", 32'(bus.ball_speed), 32'd4);
      for (int i = 0; i < 17; i++) begin
         bus.paddle_hit = 1'b1; cyc(); bus.paddle_hit = 1'b0; cyc();
      end
      chk("speed_sat", 32'(bus.ball_speed), 32'd15);

      bus.pause = 1'b1;
      seen_phys = 1'b0;
      for (int i = 0; i < 100; i++) begin
         bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
         if (bus.phys_en) seen_phys = 1'b1;
         cyc();
      end
      bus.pause = 1'b0;
      chk("pause_no_phys", 32'(seen_phys), 32'd0);
      chk("pause_state", 32'(bus.state_o), 32'd2);

      bus.goal_right = 1'b1; cyc(); bus.goal_right = 1'b0;
      chk("gr_p1", 32'(bus.p1_score),  32'd1);
      chk("gr_p2", 32'(bus.p2_score),  32'd0);
      chk("gr_dir", 32'(bus.serve_dir), 32'd1);
      chk("gr_state", 32'(bus.state_o), 32'd3);
      bus.paddle_hit = 1'b1; cyc(); bus.paddle_hit = 1'b0; cyc();
      chk("hit_in_score", 32'(bus.ball_speed), 32'd15);

      tick_n(29);
      chk("hold_29", 32'(bus.state_o), 32'd3);
      tick_n(1);
      chk("hold_30", 32'(bus.state_o), 32'd1);
      tick_n(10);
      bus.pause = 1'b1;
      tick_n(100);
      bus.pause = 1'b0;
      chk("sw_speed_held", 32'(bus.ball_speed), 32'd15);
      serve_seq("serve2", 49, 1'b1);

      bus.goal_left = 1'b1; bus.goal_right = 1'b1; cyc();
      bus.goal_left = 1'b0; bus.goal_right = 1'b0;
      chk("both_p1", 32'(bus.p1_score),  32'd1);
      chk("both_p2", 32'(bus.p2_score),  32'd0);
      chk("both_dir", 32'(bus.serve_dir), 32'd1);
      chk("both_state", 32'(bus.state_o), 32'd3);
      tick_n(30);
      serve_seq("serve3", 59, 1'b1);

      bus.goal_left = 1'b1; bus.paddle_hit = 1'b1; cyc();
      bus.goal_left = 1'b0; bus.paddle_hit = 1'b0;
      chk("glhit_p2", 32'(bus.p2_score),   32'd1);
      chk("glhit_speed", 32'(bus.ball_speed), 32'd1);
      chk("glhit_dir", 32'(bus.serve_dir),  32'd0);
      chk("glhit_state", 32'(bus.state_o),  32'd3);

      for (int i = 0; i < 8; i++) begin
         tick_n(30);
         tick_n(60);
         bus.goal_left = 1'b1; cyc(); bus.goal_left = 1'b0; cyc();
      end
      chk("p2_nine", 32'(bus.p2_score), 32'd9);
      chk("p1_one", 32'(bus.p1_score), 32'd1);
      tick_n(29);
      chk("go_pre", 32'(bus.game_over), 32'd0);
      tick_n(1);
      chk("go_flag", 32'(bus.game_over), 32'd1);
      chk("go_winner", 32'(bus.winner), 32'd1);
      chk("go_state", 32'(bus.state_o), 32'd4);

      bus.goal_right = 1'b1; cyc(); bus.goal_right = 1'b0; cyc();
      bus.goal_left  = 1'b1; cyc(); bus.goal_left  = 1'b0; cyc();
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      chk("go_hold_p1", 32'(bus.p1_score), 32'd1);
      chk("go_hold_p2", 32'(bus.p2_score), 32'd9);
      chk("go_no_phys", 32'(bus.phys_en), 32'd0);
      cyc();

      pulse_start();
      chk("restart_p1", 32'(bus.p1_score),  32'd0);
      chk("restart_p2", 32'(bus.p2_score),  32'd0);
      chk("restart_state", 32'(bus.state_o), 32'd1);
      chk("restart_dir", 32'(bus.serve_dir), 32'd1);
      chk("restart_gover", 32'(bus.game_over), 32'd0);
      cyc();
      pulse_start();
      cyc();
      chk("start_ignored_sw", 32'(bus.state_o), 32'd1);
      serve_seq("serve4", 59, 1'b1);

      bus.goal_left = 1'b1; cyc(); bus.goal_left = 1'b0; cyc();
      tick_n(30);
      serve_seq("serve5", 59, 1'b0);
      for (int i = 0; i < 2; i++) begin
         bus.paddle_hit = 1'b1; cyc(); bus.paddle_hit = 1'b0; cyc();
      end
      chk("pre_rst_speed", 32'(bus.ball_speed), 32'd3);
      chk("pre_rst_p2", 32'(bus.p2_score), 32'd1);

      bus.tick = 1'b1;
      reset    = 1'b0;
      cyc();
      bus.tick = 1'b0;
      check_reset_vals("midrst");
      reset = 1'b1;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
